instr_loader: RTL

Writer side of the 4-entry, 2-bit instruction store that the increment/add execution core reads through its program-counter bits `s1`/`s2`. The block accepts program words over a valid/ready handshake, writes them in address order into an internal register file, and tells the core when a complete program is present. It also provides the combinational read port (`instruct`) that the core consumes, so a single block replaces the fixed ROM contents.

---
 rtl/instr_loader.sv | 110 +++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// instr_loader: writer side of the instruction store read by the increment/add
// core. Program words arrive over a valid/ready handshake, are written in
// address order, and prog_ready tells the core a full program is present.
// The read port (instruct) is combinational from s2/s1.
// Optional feature: define INSTR_LOADER_PARITY_EN to check odd parity on each
// word; bad words are consumed but not written and set the sticky load_err.
module instr_loader #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 2,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              wr_valid,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              wr_parity,
  output logic              wr_ready,
  input  logic              s1,
  input  logic              s2,
  output logic [WIDTH-1:0]  instruct,
  output logic              prog_ready,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr;
  logic              beat;
  logic              word_ok;
  logic              last_beat;

  // Read port: whatever is currently stored, including a partial load.
  assign rd_addr  = ADDR_W'({s2, s1});
  assign instruct = mem[rd_addr];

`ifdef INSTR_LOADER_PARITY_EN
  // Odd parity over data plus parity bit.
  assign word_ok = ^{wr_data, wr_parity};
`else
  logic unused_parity;
  assign word_ok       = 1'b1;
  assign unused_parity = wr_parity;
`endif

  // Handshake beat; a restart in the same cycle wins and the beat is dropped.
  always_comb begin
    beat      = 1'b0;
    last_beat = 1'b0;
    if ((state == LOAD) && wr_valid && !load_start) begin
      beat = 1'b1;
    end
    if (load_count == (ADDR_W+1)'(DEPTH - 1)) begin
      last_beat = 1'b1;
    end
  end

  // Session FSM with registered ready flags, write pointer, count and memory.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ready   <= 1'b0;
      prog_ready <= 1'b0;
      wr_ptr     <= '0;
      load_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (load_start) begin
      state      <= LOAD;
      wr_ready   <= 1'b1;
      prog_ready <= 1'b0;
      wr_ptr     <= '0;
      load_count <= '0;
    end else if (beat && word_ok) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + ADDR_W'(1);
      load_count  <= load_count + (ADDR_W+1)'(1);
      if (last_beat) begin
        state      <= DONE;
        wr_ready   <= 1'b0;
        prog_ready <= 1'b1;
      end
    end
  end

`ifdef INSTR_LOADER_PARITY_EN
  // Sticky parity error, cleared only by a new session or reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_err <= 1'b0;
    end else if (load_start) begin
      load_err <= 1'b0;
    end else if (beat && !word_ok) begin
      load_err <= 1'b1;
    end
  end
`else
  assign load_err = 1'b0;
`endif

endmodule
